// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encodings and mode constants
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/fulladd.sv
// fulladd: single-bit full-adder cell
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_addsub_digit.sv
// digit_addsub: DIGIT-wide ripple of fulladd cells, exposing carry into the top cell
module digit_addsub #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             ctop
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fulladd u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co   = c[DIGIT];
  assign ctop = c[DIGIT-1];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtracter with carry, overflow and zero flags
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t             state;
  logic [WIDTH-1:0]   opa, opb;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic [DIGIT-1:0]   sum;
  logic               co, ctop, last;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]   res_next;
  digit_addsub #(.DIGIT(DIGIT)) u_dig (
    .a(opa[DIGIT-1:0]), .b(opb[DIGIT-1:0]), .ci(carry),
    .s(sum), .co(co), .ctop(ctop)
  );
  // new sum digit enters from the MSB end so the LSB digit ends up at bit 0
  assign cat      = {sum, result};
  assign res_next = cat[WIDTH+DIGIT-1:DIGIT];
  assign last     = cnt == CW'(N - 1);
  // FSM, operand shifting and flag capture with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (state != RUN) begin
      done <= 1'b0;
      if (start) begin
        opa    <= a;
        opb    <= b ^ {WIDTH{mode}};
        carry  <= mode == MODE_SUB;
        cnt    <= '0;
        result <= '0;
        c_out  <= 1'b0;
        ovf    <= 1'b0;
        zero   <= 1'b0;
        busy   <= 1'b1;
        state  <= RUN;
      end else begin
        state <= IDLE;
      end
    end else begin
      opa    <= opa >> DIGIT;
      opb    <= opb >> DIGIT;
      result <= res_next;
      carry  <= co;
      cnt    <= cnt + CW'(1);
      if (last) begin
        c_out <= co;
        ovf   <= ctop ^ co;
        zero  <= res_next == '0;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random checks of serial_addsub for DIGIT in {1,2,4,8}
module tb_serial_addsub;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [3:0] busy, done, co, ov, zr;
  logic [7:0] res [4];
  int nvec = 0, nerr = 0;
  int bcnt, dk1, dk4, npulse;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gd
    serial_addsub #(.WIDTH(8), .DIGIT(1 << g)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
      .busy(busy[g]), .done(done[g]), .result(res[g]),
      .c_out(co[g]), .ovf(ov[g]), .zero(zr[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // result and flags of every instance, packed as {c_out, ovf, zero, result}
  task automatic verify(input string tag, input logic [7:0] r, input logic c, input logic o, input logic z);
    for (int g = 0; g < 4; g++)
      chk($sformatf("%s d%0d", tag, 1 << g), {co[g], ov[g], zr[g], res[g]}, {c, o, z, r});
  endtask

  // one start pulse, then watch 12 cycles; k=0 is the cycle after the accepting edge
  task automatic go(input logic m, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; mode = m; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0; dk1 = -1; dk4 = -1; npulse = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy[0]) bcnt++;
      if (done[0]) begin
        npulse++;
        if (dk1 < 0) dk1 = k;
      end
      if (done[2] && dk4 < 0) dk4 = k;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] x, y, bb, r;
    logic [8:0] s;
    logic m, o;
    int p1, p2, bk9;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++)
      chk($sformatf("reset d%0d", 1 << g), {busy[g], done[g], co[g], ov[g], zr[g], res[g]}, '0);
    rst = 1'b0;

    go(1'b1, 8'h05, 8'h03);
    verify("sub 05-03", 8'h02, 1'b1, 1'b0, 1'b0);
    chk("busy cycles d1", bcnt, 8);
    chk("done cycle d1", dk1, 8);
    chk("done pulses d1", npulse, 1);
    chk("done cycle d4", dk4, 2);
    go(1'b1, 8'h03, 8'h05);
    verify("sub 03-05", 8'hFE, 1'b0, 1'b0, 1'b0);
    go(1'b1, 8'h80, 8'h01);
    verify("sub 80-01", 8'h7F, 1'b1, 1'b1, 1'b0);
    go(1'b0, 8'hFF, 8'h01);
    verify("add FF+01", 8'h00, 1'b1, 1'b0, 1'b1);
    go(1'b0, 8'h7F, 8'h01);
    verify("add 7F+01", 8'h80, 1'b0, 1'b1, 1'b0);
    go(1'b1, 8'h10, 8'h01);
    verify("sub 10-01", 8'h0F, 1'b1, 1'b0, 1'b0);
    chk("done cycle d4 b", dk4, 2);

    // new operands pulsed mid-RUN must not disturb the DIGIT=1 instance
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h03; b = 8'h04;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrun res d1", {co[0], ov[0], zr[0], res[0]}, {3'b000, 8'h07});

    // start held through DONE: second op starts at once, each done one cycle
    repeat (3) @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 8'h05; b = 8'h03;
    @(negedge clk);
    p1 = -1; p2 = -1; npulse = 0; bk9 = 0;
    for (int k = 0; k < 22; k++) begin
      if (done[0]) begin
        npulse++;
        if (p1 < 0) p1 = k; else if (p2 < 0) p2 = k;
      end
      if (k == 9) begin
        bk9 = busy[0];
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b pulses", npulse, 2);
    chk("b2b first", p1, 8);
    chk("b2b second", p2, 17);
    chk("b2b busy k9", bk9, 1);
    verify("b2b res", 8'h02, 1'b1, 1'b0, 1'b0);

    // reset at the 4th RUN edge
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++)
      chk($sformatf("midrst d%0d", 1 << g), {busy[g], done[g], co[g], ov[g], zr[g], res[g]}, '0);
    npulse = 0;
    repeat (10) begin
      if (done[0]) npulse++;
      @(negedge clk);
    end
    chk("no done after rst", npulse, 0);
    go(1'b0, 8'h12, 8'h34);
    verify("after rst", 8'h46, 1'b0, 1'b0, 1'b0);

    // random operands against a reference sum in both modes
    for (int i = 0; i < 1000; i++) begin
      m = i[0];
      x = 8'($urandom);
      y = 8'($urandom);
      bb = m ? ~y : y;
      s = {1'b0, x} + {1'b0, bb} + {8'b0, m};
      r = s[7:0];
      o = (x[7] == bb[7]) && (r[7] != x[7]);
      go(m, x, y);
      verify($sformatf("rnd%0d %0d %h %h", i, m, x, y), r, s[8], o, r == 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
